// File: rtl/hazard_tracker_if.sv
// hazard_pkg: shared writeback selector type for the forwarding interface.
// hazard_tracker_if: bundle between the decode/EX control logic, the data
// memory, and the hazard tracker.
//   master : drives the decode fields, branch_taken and mem_ready, and
//            observes the forwarding state and the pipeline controls.
//   slave  : the hazard tracker itself.
package hazard_pkg;
  typedef enum logic [1:0] {
    NO_WRITEBACK = 2'd0,
    WB_ALU       = 2'd1,
    WB_MEM       = 2'd2,
    WB_PC4       = 2'd3
  } write_back_mux_selector;
endpackage

interface hazard_tracker_if #(parameter int CNT_W = 16);
  import hazard_pkg::*;

  logic                   id_valid_ip;
  logic [6:0]             id_instr_opcode_ip;
  logic [4:0]             id_rs1_ip;
  logic [4:0]             id_rs2_ip;
  logic [4:0]             id_rd_ip;
  write_back_mux_selector id_wb_mux_ip;
  logic                   id_is_load_ip;
  logic                   branch_taken_ip;
  logic                   mem_ready_ip;

  logic [4:0]             EX_MEM_dest_op;
  logic [4:0]             MEM_WB_dest_op;
  write_back_mux_selector EX_MEM_wb_mux_op;
  write_back_mux_selector MEM_WB_wb_mux_op;
  logic                   stall_if_op;
  logic                   stall_id_op;
  logic                   stall_ex_op;
  logic                   bubble_ex_op;
  logic                   flush_id_op;
  logic [CNT_W-1:0]       stall_cnt_op;

  modport master (
    output id_valid_ip, id_instr_opcode_ip, id_rs1_ip, id_rs2_ip, id_rd_ip,
           id_wb_mux_ip, id_is_load_ip, branch_taken_ip, mem_ready_ip,
    input  EX_MEM_dest_op, MEM_WB_dest_op, EX_MEM_wb_mux_op, MEM_WB_wb_mux_op,
           stall_if_op, stall_id_op, stall_ex_op, bubble_ex_op, flush_id_op,
           stall_cnt_op
  );

  modport slave (
    input  id_valid_ip, id_instr_opcode_ip, id_rs1_ip, id_rs2_ip, id_rd_ip,
           id_wb_mux_ip, id_is_load_ip, branch_taken_ip, mem_ready_ip,
    output EX_MEM_dest_op, MEM_WB_dest_op, EX_MEM_wb_mux_op, MEM_WB_wb_mux_op,
           stall_if_op, stall_id_op, stall_ex_op, bubble_ex_op, flush_id_op,
           stall_cnt_op
  );
endinterface

// File: rtl/hazard_tracker.sv
// hazard_tracker: shadows {rd, wb_mux, is_load} of every in-flight
// instruction through ID/EX, EX/MEM and MEM/WB, publishes the EX/MEM and
// MEM/WB copies to the forwarding controller, and raises the stall / bubble
// / flush controls for the cases forwarding cannot cover (load-use, data
// memory wait, taken branch).
// Ports:
//   clk   : core clock, rising edge
//   reset : synchronous active-low reset
//   hz    : hazard_tracker_if.slave (decode fields, branch/mem status in;
//           forwarding state, pipeline controls, stall counter out)
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  hazard_tracker_if.slave hz
);

  typedef struct packed {
    logic [4:0]             dest;
    write_back_mux_selector wb_mux;
    logic                   is_load;
  } entry_t;

  localparam entry_t BUBBLE = '{dest: 5'd0, wb_mux: NO_WRITEBACK, is_load: 1'b0};

  entry_t           id_ex, ex_mem, mem_wb;
  logic [CNT_W-1:0] stall_cnt;

  logic rs1_used, rs2_used, raw_hit;
  logic mem_wait, flush, load_use;

  // Which source registers the decode instruction actually reads; opcodes
  // without a source (LUI, AUIPC, JAL, ...) must never cause a stall.
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (hz.id_instr_opcode_ip)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: rs1_used = 1'b1;
      default: ;
    endcase
  end

  assign raw_hit = (rs1_used && hz.id_rs1_ip == id_ex.dest) ||
                   (rs2_used && hz.id_rs2_ip == id_ex.dest);

  // Priority: mem wait > branch flush > load-use. A branch seen during a
  // mem wait is simply held in EX and acted on once the wait clears.
  assign mem_wait = ex_mem.is_load & ~hz.mem_ready_ip;
  assign flush    = ~mem_wait & hz.branch_taken_ip;
  assign load_use = ~mem_wait & ~hz.branch_taken_ip & hz.id_valid_ip &
                    id_ex.is_load & (id_ex.dest != 5'd0) & raw_hit;

  assign hz.stall_if_op  = mem_wait | load_use;
  assign hz.stall_id_op  = mem_wait | load_use;
  assign hz.stall_ex_op  = mem_wait;
  assign hz.bubble_ex_op = flush | load_use;
  assign hz.flush_id_op  = flush;

  assign hz.EX_MEM_dest_op   = ex_mem.dest;
  assign hz.EX_MEM_wb_mux_op = ex_mem.wb_mux;
  assign hz.MEM_WB_dest_op   = mem_wb.dest;
  assign hz.MEM_WB_wb_mux_op = mem_wb.wb_mux;
  assign hz.stall_cnt_op     = stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      id_ex     <= BUBBLE;
      ex_mem    <= BUBBLE;
      mem_wb    <= BUBBLE;
      stall_cnt <= '0;
    end else begin
      if (mem_wait) begin
        // ID/EX and EX/MEM freeze; the retiring slot must not write twice.
        mem_wb <= BUBBLE;
      end else begin
        mem_wb <= ex_mem;
        ex_mem <= id_ex;
        if (flush || load_use || !hz.id_valid_ip)
          id_ex <= BUBBLE;
        else
          id_ex <= '{dest: hz.id_rd_ip, wb_mux: hz.id_wb_mux_ip,
                     is_load: hz.id_is_load_ip};
      end
      if ((mem_wait || load_use) && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Scoreboard bench: every driven cycle pushes its expected observation; a
// monitor pops it 2 ns after the driving negedge (well before the next
// posedge) and compares. dut uses CNT_W=16, dut_s uses CNT_W=4 for the
// saturation case.
module tb_hazard_tracker;
  import hazard_pkg::*;

  localparam logic [6:0] ADD = 7'b0110011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] LUI = 7'b0110111;
  // control vector order: {stall_if, stall_id, stall_ex, bubble_ex, flush_id}
  localparam logic [4:0] C0 = 5'b00000;
  localparam logic [4:0] LU = 5'b11010;
  localparam logic [4:0] MW = 5'b11100;
  localparam logic [4:0] FL = 5'b00011;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_tracker_if #(.CNT_W(16)) bus ();
  hazard_tracker_if #(.CNT_W(4))  bus_s ();

  hazard_tracker #(.CNT_W(16)) dut   (.clk(clk), .reset(reset), .hz(bus.slave));
  hazard_tracker #(.CNT_W(4))  dut_s (.clk(clk), .reset(reset), .hz(bus_s.slave));

  typedef struct {
    bit          sel;
    int          cyc;
    logic [4:0]  exd, wbd;
    logic [1:0]  exwb, wbwb;
    logic [4:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = -1;
  bit   cur_sel = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  task automatic drv(bit sel, logic rst, logic v, logic [6:0] op,
                     logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                     logic [1:0] wb, logic ld, logic br, logic rdy);
    @(negedge clk);
    cyc++;
    cur_sel = sel;
    reset   = rst;
    bus.id_valid_ip = 0; bus.id_instr_opcode_ip = 0; bus.id_rs1_ip = 0;
    bus.id_rs2_ip = 0; bus.id_rd_ip = 0; bus.id_wb_mux_ip = NO_WRITEBACK;
    bus.id_is_load_ip = 0; bus.branch_taken_ip = 0; bus.mem_ready_ip = 1;
    bus_s.id_valid_ip = 0; bus_s.id_instr_opcode_ip = 0; bus_s.id_rs1_ip = 0;
    bus_s.id_rs2_ip = 0; bus_s.id_rd_ip = 0; bus_s.id_wb_mux_ip = NO_WRITEBACK;
    bus_s.id_is_load_ip = 0; bus_s.branch_taken_ip = 0; bus_s.mem_ready_ip = 1;
    if (!sel) begin
      bus.id_valid_ip = v; bus.id_instr_opcode_ip = op; bus.id_rs1_ip = r1;
      bus.id_rs2_ip = r2; bus.id_rd_ip = rd;
      bus.id_wb_mux_ip = write_back_mux_selector'(wb);
      bus.id_is_load_ip = ld; bus.branch_taken_ip = br; bus.mem_ready_ip = rdy;
    end else begin
      bus_s.id_valid_ip = v; bus_s.id_instr_opcode_ip = op; bus_s.id_rs1_ip = r1;
      bus_s.id_rs2_ip = r2; bus_s.id_rd_ip = rd;
      bus_s.id_wb_mux_ip = write_back_mux_selector'(wb);
      bus_s.id_is_load_ip = ld; bus_s.branch_taken_ip = br; bus_s.mem_ready_ip = rdy;
    end
  endtask

  task automatic nop(bit sel, logic br, logic rdy);
    drv(sel, 1'b1, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, br, rdy);
  endtask

  task automatic ex(logic [4:0] exd, logic [1:0] exwb, logic [4:0] wbd,
                    logic [1:0] wbwb, logic [4:0] ctl, int cnt);
    exp_t x;
    x.sel = cur_sel; x.cyc = cyc;
    x.exd = exd; x.exwb = exwb; x.wbd = wbd; x.wbwb = wbwb;
    x.ctl = ctl; x.cnt = 16'(cnt);
    sb.push_back(x);
  endtask

  // Monitor: compare one queued expectation per cycle, 2 ns after negedge.
  always begin
    @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.sel) begin
        chk($sformatf("c%0d/ex_dest", e.cyc), bus.EX_MEM_dest_op, e.exd);
        chk($sformatf("c%0d/ex_wb", e.cyc), bus.EX_MEM_wb_mux_op, e.exwb);
        chk($sformatf("c%0d/wb_dest", e.cyc), bus.MEM_WB_dest_op, e.wbd);
        chk($sformatf("c%0d/wb_wb", e.cyc), bus.MEM_WB_wb_mux_op, e.wbwb);
        chk($sformatf("c%0d/ctl", e.cyc),
            {bus.stall_if_op, bus.stall_id_op, bus.stall_ex_op,
             bus.bubble_ex_op, bus.flush_id_op}, e.ctl);
        chk($sformatf("c%0d/cnt", e.cyc), bus.stall_cnt_op, e.cnt);
      end else begin
        chk($sformatf("s%0d/ex_dest", e.cyc), bus_s.EX_MEM_dest_op, e.exd);
        chk($sformatf("s%0d/ex_wb", e.cyc), bus_s.EX_MEM_wb_mux_op, e.exwb);
        chk($sformatf("s%0d/wb_dest", e.cyc), bus_s.MEM_WB_dest_op, e.wbd);
        chk($sformatf("s%0d/wb_wb", e.cyc), bus_s.MEM_WB_wb_mux_op, e.wbwb);
        chk($sformatf("s%0d/ctl", e.cyc),
            {bus_s.stall_if_op, bus_s.stall_id_op, bus_s.stall_ex_op,
             bus_s.bubble_ex_op, bus_s.flush_id_op}, e.ctl);
        chk($sformatf("s%0d/cnt", e.cyc), 32'(bus_s.stall_cnt_op), e.cnt);
      end
    end
  end

  initial begin
    // Reset held two cycles with a live instruction on the decode inputs.
    drv(0, 0, 1, ADD, 1, 2, 5, 1, 0, 0, 1);
    drv(0, 0, 1, ADD, 1, 2, 5, 1, 0, 0, 1); ex(0, 0, 0, 0, C0, 0);
    // Latency: ADD rd=7 accepted at the end of this cycle.
    drv(0, 1, 1, ADD, 1, 2, 7, 1, 0, 0, 1); ex(0, 0, 0, 0, C0, 0);
    nop(0, 0, 1); ex(0, 0, 0, 0, C0, 0);
    nop(0, 0, 1); ex(7, 1, 0, 0, C0, 0);
    nop(0, 0, 1); ex(0, 0, 7, 1, C0, 0);
    // Load-use: LW rd=3 then ADD rs1=3.
    drv(0, 1, 1, LW,  1, 0, 3, 2, 1, 0, 1); ex(0, 0, 0, 0, C0, 0);
    drv(0, 1, 1, ADD, 3, 0, 8, 1, 0, 0, 1); ex(0, 0, 0, 0, LU, 0);
    drv(0, 1, 1, ADD, 3, 0, 8, 1, 0, 0, 1); ex(3, 2, 0, 0, C0, 1);
    nop(0, 0, 1); ex(0, 0, 3, 2, C0, 1);
    nop(0, 0, 1); ex(8, 1, 0, 0, C0, 1);
    nop(0, 0, 1); ex(0, 0, 8, 1, C0, 1);
    // No false stall: LW rd=0 -> ADD rs1=0; LW rd=4 -> LUI.
    drv(0, 1, 1, LW,  2, 0, 0, 2, 1, 0, 1); ex(0, 0, 0, 0, C0, 1);
    drv(0, 1, 1, ADD, 0, 0, 9, 1, 0, 0, 1); ex(0, 0, 0, 0, C0, 1);
    drv(0, 1, 1, LW,  0, 0, 4, 2, 1, 0, 1); ex(0, 2, 0, 0, C0, 1);
    drv(0, 1, 1, LUI, 4, 4, 10, 1, 0, 0, 1); ex(9, 1, 0, 2, C0, 1);
    nop(0, 0, 1); ex(4, 2, 9, 1, C0, 1);
    nop(0, 0, 1); ex(10, 1, 4, 2, C0, 1);
    nop(0, 0, 1); ex(0, 0, 10, 1, C0, 1);
    // Mem wait for 3 cycles with branch_taken asserted, then flush.
    drv(0, 1, 1, LW,  1, 0, 6, 2, 1, 0, 1); ex(0, 0, 0, 0, C0, 1);
    drv(0, 1, 1, ADD, 2, 2, 11, 1, 0, 0, 1); ex(0, 0, 0, 0, C0, 1);
    for (int k = 0; k < 3; k++) begin
      nop(0, 1, 0); ex(6, 2, 0, 0, MW, 1 + k);
    end
    nop(0, 1, 1); ex(6, 2, 0, 0, FL, 4);
    nop(0, 0, 1); ex(11, 1, 6, 2, C0, 4);
    nop(0, 0, 1); ex(0, 0, 11, 1, C0, 4);
    // Branch suppresses load-use; then reset in the middle of a mem wait.
    drv(0, 1, 1, LW,  1, 0, 5, 2, 1, 0, 1); ex(0, 0, 0, 0, C0, 4);
    drv(0, 1, 1, ADD, 0, 5, 12, 1, 0, 1, 1); ex(0, 0, 0, 0, FL, 4);
    nop(0, 0, 0); ex(5, 2, 0, 0, MW, 4);
    drv(0, 0, 0, 7'd0, 0, 0, 0, 0, 0, 0, 0); ex(5, 2, 0, 0, MW, 5);
    nop(0, 0, 0); ex(0, 0, 0, 0, C0, 0);
    // Saturation on the 4-bit counter instance.
    drv(1, 1, 1, LW, 1, 0, 2, 2, 1, 0, 1); ex(0, 0, 0, 0, C0, 0);
    nop(1, 0, 0); ex(0, 0, 0, 0, C0, 0);
    for (int k = 0; k < 22; k++) begin
      nop(1, 0, 0); ex(2, 2, 0, 0, MW, (k < 15) ? k : 15);
    end
    nop(1, 0, 1);
    @(negedge clk);
    #4;
    chk("drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
